axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Shares one AXI4 read master port (AR/R channels) between NUM_REQ requesters, e.g. instruction fetch and data load, in front of the AXI4 memory slave. Round-robin arbitration; exactly one burst outstanding at a time, and the grant is held from the AR handshake through the RLAST beat. R beats are steered only to the granted requester. Burst length is checked against RLAST, and a sticky error flag is raised on mismatch.

## Interface
Parameters:
- ADDR_WIDTH, 40: address width.
- DATA_WIDTH, 128: data width.
- ID_WIDTH, 4: AXI ID width; IDs pass through unmodified.
- NUM_REQ, 2: number of requesters (2..8).

Ports (clock and reset first; the `S_*` buses are flattened, with requester i in slice i):
- ACLK  in  1  clock; all logic on rising edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- S_ARVALID  in  NUM_REQ  per-requester AR valid.
- S_ARREADY  out  NUM_REQ  per-requester AR ready.
- S_ARID  in  NUM_REQ*ID_WIDTH  per-requester AR ID.
- S_ARADDR  in  NUM_REQ*ADDR_WIDTH  per-requester AR address.
- S_ARLEN  in  NUM_REQ*8  per-requester AR length.
- S_ARSIZE  in  NUM_REQ*3  per-requester AR size.
- S_ARBURST  in  NUM_REQ*2  per-requester AR burst type.
- S_RVALID  out  NUM_REQ  per-requester R valid.
- S_RREADY  in  NUM_REQ  per-requester R ready.
- S_RID  out  ID_WIDTH  R ID, shared broadcast to all requesters.
- S_RDATA  out  DATA_WIDTH  R data, shared broadcast.
- S_RRESP  out  2  R response, shared broadcast.
- S_RLAST  out  1  R last, shared broadcast.
- M_ARVALID, M_ARREADY, M_ARID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST  out/in/out...  master AR channel.
- M_RVALID, M_RREADY, M_RID, M_RDATA, M_RRESP, M_RLAST  in/out/in...  master R channel.
- GRANT  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- BUSY  out  1  state != IDLE.
- ERR_LAST  out  1  sticky; set on a burst-length/RLAST mismatch.

## Operation
State machine:
- IDLE
  - If any S_ARVALID bit is set, pick the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Register the pick into grant; go to ADDR.
- ADDR
  - M_AR* payload is muxed combinationally from S_AR*[grant].
  - M_ARVALID = S_ARVALID[grant].
  - S_ARREADY[grant] = M_ARREADY; all other S_ARREADY bits = 0.
  - On M_ARVALID & M_ARREADY: latch ARLEN into beats_left, clear the beat counter, go to DATA.
- DATA
  - S_RVALID[grant] = M_RVALID; other S_RVALID bits = 0.
  - M_RREADY = S_RREADY[grant].
  - S_R* payload = M_R*.
  - Each handshake decrements beats_left.
  - On the handshake with M_RLAST=1: last_grant <= grant; go to IDLE.
- ADDR, S_ARVALID[grant] deasserted without a handshake (requester protocol violation): return to IDLE; last_grant is not updated.
- ERR_LAST is set, and stays set, in either case:
  - M_RLAST=1 on a beat with beats_left != 0.
  - M_RLAST=0 on a beat with beats_left == 0. The arbiter stays in DATA until RLAST arrives.
- Non-granted requesters see S_ARREADY=0 and S_RVALID=0 at all times.
- RRESP (including 2'b10 and 2'b11) is forwarded unmodified; an error response does not end the burst early.

## Timing
- Reset:
  - state = IDLE, grant = 0, last_grant = NUM_REQ-1, so requester 0 wins first.
  - beats_left = 0, ERR_LAST = 0.
  - All S_ARREADY, S_RVALID, M_ARVALID and M_RREADY are 0.
  - BUSY = 0, GRANT = 0.
- Reset mid-burst returns to IDLE immediately (asynchronous). No beats are forwarded afterwards.
- Latency from S_ARVALID rising in IDLE to M_ARVALID: 1 cycle.
- AR path: the ADDR→master path is combinational, with zero added latency after the grant.
- R path: fully combinational passthrough; no buffering, zero latency.
- Minimum gap between bursts: one IDLE cycle after the RLAST handshake, so back-to-back bursts take 1 bubble cycle.
- Simultaneous requests in IDLE: the round-robin pointer decides. A requester asserting valid while another burst is in ADDR or DATA waits.
- beats_left is 8 bits. The ARLEN=0 (single-beat) burst is legal and must complete in one beat without setting ERR_LAST.

## Test plan
- Single request:
  - Stimulus: req0 ARADDR=0x10000, ARLEN=3, slave always ready.
  - Response: M_ARVALID one cycle after S_ARVALID; 4 beats reach req0 only; S_RVALID[1] stays 0; GRANT=0; ERR_LAST=0; back in IDLE the cycle after RLAST.
- Round-robin:
  - Stimulus: req0 and req1 both hold valid continuously with ARLEN=0.
  - Response: grants alternate 0,1,0,1; each burst is separated by exactly one IDLE cycle.
- Backpressure:
  - Stimulus: M_ARREADY held low 5 cycles; S_RREADY[0] toggles every other cycle during an ARLEN=7 burst.
  - Response: no beat is lost or duplicated; 8 beats delivered in order; M_RREADY tracks S_RREADY[0].
- RLAST mismatch:
  - Stimulus: slave asserts RLAST on beat 2 of an ARLEN=3 burst.
  - Response: ERR_LAST=1, which persists into later bursts; the arbiter returns to IDLE.
- Error response passthrough:
  - Stimulus: ARADDR=0x0 (out of the slave's range).
  - Response: every beat carries S_RRESP=2'b10, and the full burst length is delivered.
- Reset mid-burst:
  - Stimulus: assert ARESETn=0 during beat 2 of an ARLEN=7 burst.
  - Response: all valids and readies are 0 immediately. After release, the next simultaneous request grants req0.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: requester-side (S_*) and memory-side (M_*)
// AR/R buses of the read arbiter; requester buses flattened per slice.
interface axi_read_arbiter_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            S_ARVALID;
  logic [NUM_REQ-1:0]            S_ARREADY;
  logic [NUM_REQ*ID_WIDTH-1:0]   S_ARID;
  logic [NUM_REQ*ADDR_WIDTH-1:0] S_ARADDR;
  logic [NUM_REQ*8-1:0]          S_ARLEN;
  logic [NUM_REQ*3-1:0]          S_ARSIZE;
  logic [NUM_REQ*2-1:0]          S_ARBURST;
  logic [NUM_REQ-1:0]            S_RVALID;
  logic [NUM_REQ-1:0]            S_RREADY;
  logic [ID_WIDTH-1:0]           S_RID;
  logic [DATA_WIDTH-1:0]         S_RDATA;
  logic [1:0]                    S_RRESP;
  logic                          S_RLAST;

  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [ID_WIDTH-1:0]   M_ARID;
  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic [7:0]            M_ARLEN;
  logic [2:0]            M_ARSIZE;
  logic [1:0]            M_ARBURST;
  logic                  M_RVALID;
  logic                  M_RREADY;
  logic [ID_WIDTH-1:0]   M_RID;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RLAST;

  modport slave (
    input  S_ARVALID, S_ARID, S_ARADDR, S_ARLEN,
    input  S_ARSIZE, S_ARBURST, S_RREADY,
    output S_ARREADY, S_RVALID, S_RID, S_RDATA,
    output S_RRESP, S_RLAST,
    output M_ARVALID, M_ARID, M_ARADDR, M_ARLEN,
    output M_ARSIZE, M_ARBURST, M_RREADY,
    input  M_ARREADY, M_RVALID, M_RID, M_RDATA,
    input  M_RRESP, M_RLAST
  );

  modport master (
    output S_ARVALID, S_ARID, S_ARADDR, S_ARLEN,
    output S_ARSIZE, S_ARBURST, S_RREADY,
    input  S_ARREADY, S_RVALID, S_RID, S_RDATA,
    input  S_RRESP, S_RLAST,
    input  M_ARVALID, M_ARID, M_ARADDR, M_ARLEN,
    input  M_ARSIZE, M_ARBURST, M_RREADY,
    output M_ARREADY, M_RVALID, M_RID, M_RDATA,
    output M_RRESP, M_RLAST
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin share of one AXI4 read master port,
// one burst in flight, sticky RLAST/length mismatch flag.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 40,
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int NUM_REQ    = 2
) (
  input  logic                       ACLK,
  input  logic                       ARESETn,
  axi_read_arbiter_if.slave          bus,
  output logic [$clog2(NUM_REQ)-1:0] GRANT,
  output logic                       BUSY,
  output logic                       ERR_LAST
);
  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         idx;
  logic                  found;
  logic [7:0]            beats_left;
  logic                  err_last;
  logic [NUM_REQ-1:0]    gsel;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ar_hs;
  logic                  r_hs;

  assign gsel = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;

  // search starts one past the last winner so every requester gets a turn
  always_comb begin
    pick  = grant;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (!found && bus.S_ARVALID[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign bus.M_ARVALID = (state == ADDR) & bus.S_ARVALID[grant];
  assign bus.M_ARID    = bus.S_ARID[int'(grant)*ID_WIDTH +: ID_WIDTH];
  assign bus.M_ARADDR  = bus.S_ARADDR[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.M_ARLEN   = bus.S_ARLEN[int'(grant)*8 +: 8];
  assign bus.M_ARSIZE  = bus.S_ARSIZE[int'(grant)*3 +: 3];
  assign bus.M_ARBURST = bus.S_ARBURST[int'(grant)*2 +: 2];
  assign bus.S_ARREADY =
    (state == ADDR && bus.M_ARREADY) ? gsel : '0;

  assign bus.S_RVALID =
    (state == DATA && bus.M_RVALID) ? gsel : '0;
  assign bus.M_RREADY = (state == DATA) & bus.S_RREADY[grant];
  assign rdata        = bus.M_RDATA;
  assign bus.S_RDATA  = rdata;
  assign bus.S_RID    = bus.M_RID;
  assign bus.S_RRESP  = bus.M_RRESP;
  assign bus.S_RLAST  = bus.M_RLAST;

  assign ar_hs = bus.M_ARVALID & bus.M_ARREADY;
  assign r_hs  = (state == DATA) & bus.M_RVALID & bus.M_RREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beats_left <= 8'd0;
      err_last   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|bus.S_ARVALID) begin
            grant <= pick;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ar_hs) begin
            beats_left <= bus.M_ARLEN;
            state      <= DATA;
          end else if (!bus.S_ARVALID[grant]) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (beats_left != 8'd0)
              beats_left <= beats_left - 8'd1;
            // RLAST must coincide exactly with the final counted beat
            if (bus.M_RLAST != (beats_left == 8'd0))
              err_last <= 1'b1;
            if (bus.M_RLAST) begin
              last_grant <= grant;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign GRANT    = grant;
  assign BUSY     = (state != IDLE);
  assign ERR_LAST = err_last;
endmodule
